// File: rtl/bcd_div_seq.sv
`default_nettype none
// ============================================================================
// Module  : bcd_div_seq
// Brief   : Sequential restoring digit-serial packed-BCD divider (q = a / b, r = a mod b).
// Revision: 1.0 - initial release
// ============================================================================
module bcd_div_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [N*4-1:0] a,
  input  logic [N*4-1:0] b,
  output logic [N*4-1:0] q,
  output logic [N*4-1:0] r,
  output logic           busy,
  output logic           done,
  output logic           dbz
);

  localparam int W  = N * 4;
  localparam int RW = W + 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_SUB   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IW-1:0] C_LAST_IDX = IW'(N - 1);
  localparam logic [3:0]    C_CNT_MAX  = 4'd9;

  logic [1:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [RW-1:0] r_rem;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_r;
  logic [3:0]    r_cnt;
  logic [IW-1:0] r_idx;
  logic          r_dbz;

  logic [RW-1:0] w_bx;
  logic [RW-1:0] w_diff;
  logic          w_borrow;
  logic          w_accept;

  assign w_bx     = {4'd0, r_b};
  assign w_accept = ld && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Ten's-complement subtraction, one decimal digit at a time with ripple borrow.
  always_comb begin
    logic [4:0] v_t;
    logic       v_b;
    v_b    = 1'b0;
    v_t    = 5'd0;
    w_diff = '0;
    for (int i = 0; i <= N; i++) begin
      v_t = {1'b0, r_rem[i*4 +: 4]} - {1'b0, w_bx[i*4 +: 4]} - {4'd0, v_b};
      if (v_t[4]) begin
        v_t = v_t + 5'd10;
        v_b = 1'b1;
      end else begin
        v_b = 1'b0;
      end
      w_diff[i*4 +: 4] = v_t[3:0];
    end
    w_borrow = v_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_rem <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_idx <= C_LAST_IDX;
      if (b == '0) begin
        r_state <= S_DONE;
        r_dbz   <= 1'b1;
        r_r     <= a;
      end else begin
        r_state <= S_SHIFT;
        r_dbz   <= 1'b0;
        r_r     <= '0;
      end
    end else begin
      case (r_state)
        S_SHIFT: begin
          // Dividend is consumed from its top nibble; the register shifts instead of indexing.
          r_rem   <= {r_rem[W-1:0], r_a[W-1 -: 4]};
          r_a     <= r_a << 4;
          r_cnt   <= '0;
          r_state <= S_SUB;
        end
        S_SUB: begin
          if (!w_borrow && (r_cnt < C_CNT_MAX)) begin
            r_rem <= w_diff;
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_q <= (r_q << 4) | W'(r_cnt);
            if (r_idx == '0) begin
              r_r     <= r_rem[W-1:0];
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx - IW'(1);
              r_state <= S_SHIFT;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign q    = r_q;
  assign r    = r_r;
  assign dbz  = r_dbz;
  assign busy = (r_state == S_SHIFT) || (r_state == S_SUB);
  assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_div_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_div_seq
// Brief   : Directed + random checks of bcd_div_seq against an integer-arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bcd_div_seq;

  localparam int N = 8;
  localparam int W = N * 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ld  = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         dbz;

  int n_checks = 0;
  int n_err    = 0;
  int lat;
  bit both;
  bit saw_busy;
  bit saw_done;

  bcd_div_seq #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint s = 0;
    for (int i = N - 1; i >= 0; i--) s = s * 10 + longint'(v[i*4 +: 4]);
    return s;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint x);
    logic [W-1:0] res = '0;
    for (int i = 0; i < N; i++) begin
      res[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return res;
  endfunction

  function automatic int digsum(input longint x);
    int s = 0;
    while (x > 0) begin
      s = s + int'(x % 10);
      x = x / 10;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] rand_bcd(input int ndig);
    logic [W-1:0] v = '0;
    for (int i = 0; i < ndig; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents operands with ld high so the next rising edge samples them.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    a  = av;
    b  = bv;
    ld = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
  endtask

  // Counts edges after the ld edge until done is observed (bounded).
  task automatic wait_done(input int start);
    lat      = start;
    both     = busy && done;
    saw_busy = busy;
    while (!done && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy && done) both = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    longint ai = bcd2int(av);
    longint bi = bcd2int(bv);
    if (bi == 0) begin
      check({tag, "_lat"}, 64'(lat), 64'd0);
      check({tag, "_q"},   64'(q), 64'd0);
      check({tag, "_r"},   64'(r), 64'(av));
      check({tag, "_dbz"}, 64'(dbz), 64'd1);
    end else begin
      check({tag, "_lat"}, 64'(lat), 64'(2 * N + digsum(ai / bi)));
      check({tag, "_q"},   64'(q), 64'(int2bcd(ai / bi)));
      check({tag, "_r"},   64'(r), 64'(int2bcd(ai % bi)));
      check({tag, "_dbz"}, 64'(dbz), 64'd0);
    end
    check({tag, "_excl"}, 64'(both), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start_op(av, bv);
    wait_done(0);
    check_result(tag, av, bv);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {q, r, busy, done, dbz}, '0);
    @(negedge clk);
    rst = 1'b0;

    run_op("div_100_7", 32'h0000_0100, 32'h0000_0007);
    repeat (3) @(posedge clk);
    #1;
    check("hold_q", 64'(q), 64'h14);
    check("hold_r", 64'(r), 64'h2);
    check("hold_flags", {busy, done, dbz}, 3'b000);

    run_op("max_lat", 32'h9999_9999, 32'h0000_0001);
    run_op("min_lat", 32'h0000_0005, 32'h0000_0009);
    run_op("dbz", 32'h1234_5678, 32'h0000_0000);
    check("dbz_busy_never", 64'(saw_busy), 64'd0);

    // ld during the division is ignored; operand changes are ignored too.
    @(negedge clk);
    start_op(32'h0000_0100, 32'h0000_0007);
    repeat (4) @(posedge clk);
    a  = 32'h0000_0050;
    b  = 32'h0000_0025;
    ld = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
    a  = 32'h9999_9999;
    b  = 32'h0000_0003;
    wait_done(5);
    check_result("ld_ignored", 32'h0000_0100, 32'h0000_0007);

    // Asynchronous reset mid-operation aborts with no done pulse.
    @(negedge clk);
    start_op(32'h0000_0100, 32'h0000_0007);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("async_rst_outs", {q, r, busy, done, dbz}, '0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    start_op(32'h0000_0099, 32'h0000_0009);
    if (done) saw_done = 1'b1;
    check("rst_no_done", 64'(saw_done), 64'd0);
    wait_done(0);
    check_result("after_rst", 32'h0000_0099, 32'h0000_0009);

    // Back-to-back: ld in the done cycle starts the next operation.
    run_op("b2b_first", 32'h0000_0100, 32'h0000_0007);
    start_op(32'h0000_0050, 32'h0000_0025);
    wait_done(0);
    check_result("b2b_second", 32'h0000_0050, 32'h0000_0025);

    for (int k = 0; k < 12; k++) begin
      ra = rand_bcd($urandom_range(1, N));
      rb = rand_bcd($urandom_range(1, 4));
      if (k == 11) rb = '0;
      run_op($sformatf("rand%0d", k), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
